// File: rtl/conv_enc_framer.sv
// conv_enc_framer: frames an upstream byte stream into a rate-1/2, K=4
// convolutional code stream. Each frame is the payload bits (MSB first)
// followed by three zero tail bits that return the encoder to state 000.
// Every frame is followed by GAP_CYCLES idle cycles. enc_d/enc_enable are
// registered and lead the internal state by one cycle, so a byte accepted in
// cycle N shows its first code pair in cycle N+1.
module conv_enc_framer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [1:0]  enc_d,
  output logic        enc_enable,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  byte_q, byte_nxt;
  logic        last_q, last_nxt;
  logic [2:0]  sr_q, sr_nxt;
  logic [2:0]  bit_idx_q, bit_idx_nxt;
  logic [1:0]  tail_cnt_q, tail_cnt_nxt;
  logic [3:0]  gap_cnt_q, gap_cnt_nxt;
  logic [1:0]  enc_d_nxt;
  logic        enc_enable_nxt;
  logic        frame_done_nxt;
  logic        underrun_nxt;
  logic [15:0] bit_count_nxt;
  logic        bit_in;

  // Code pair {c0, c1} for input bit b with encoder state sr (sr[2] newest):
  // c0 uses taps 1101, c1 uses taps 1111.
  function automatic logic [1:0] enc_pair(input logic b, input logic [2:0] sr);
    enc_pair = {b ^ sr[2] ^ sr[0], b ^ sr[2] ^ sr[1] ^ sr[0]};
  endfunction

  // Saturating increment for the emitted-pair counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and next-output logic; outputs are precomputed one cycle ahead.
  always_comb begin
    state_nxt      = state;
    byte_nxt       = byte_q;
    last_nxt       = last_q;
    sr_nxt         = sr_q;
    bit_idx_nxt    = bit_idx_q;
    tail_cnt_nxt   = tail_cnt_q;
    gap_cnt_nxt    = gap_cnt_q;
    enc_d_nxt      = 2'b00;
    enc_enable_nxt = 1'b0;
    frame_done_nxt = 1'b0;
    underrun_nxt   = 1'b0;
    bit_count_nxt  = enc_enable ? sat_inc(bit_count) : bit_count;
    bit_in         = 1'b0;
    s_ready        = 1'b0;

    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // New frame: encoder starts from the all-zero state.
          bit_in         = s_data[7];
          byte_nxt       = s_data;
          last_nxt       = s_last;
          enc_d_nxt      = enc_pair(bit_in, 3'b000);
          sr_nxt         = {bit_in, 2'b00};
          enc_enable_nxt = 1'b1;
          bit_idx_nxt    = 3'd0;
          bit_count_nxt  = 16'd0;
          state_nxt      = ENC;
        end
      end

      ENC: begin
        if (bit_idx_q != 3'd7) begin
          bit_in         = byte_q[3'd6 - bit_idx_q];
          enc_d_nxt      = enc_pair(bit_in, sr_q);
          sr_nxt         = {bit_in, sr_q[2:1]};
          enc_enable_nxt = 1'b1;
          bit_idx_nxt    = bit_idx_q + 3'd1;
        end else begin
          // Last bit of the byte is on enc_d now; next byte may follow with no bubble.
          s_ready = ~last_q;
          if (!last_q && s_valid) begin
            bit_in         = s_data[7];
            byte_nxt       = s_data;
            last_nxt       = s_last;
            enc_d_nxt      = enc_pair(bit_in, sr_q);
            sr_nxt         = {bit_in, sr_q[2:1]};
            enc_enable_nxt = 1'b1;
            bit_idx_nxt    = 3'd0;
          end else begin
            // Frame ends: normally on s_last, or early when upstream starves.
            underrun_nxt   = ~last_q;
            enc_d_nxt      = enc_pair(1'b0, sr_q);
            sr_nxt         = {1'b0, sr_q[2:1]};
            enc_enable_nxt = 1'b1;
            tail_cnt_nxt   = 2'd0;
            state_nxt      = TAIL;
          end
        end
      end

      TAIL: begin
        if (tail_cnt_q != 2'd2) begin
          enc_d_nxt      = enc_pair(1'b0, sr_q);
          sr_nxt         = {1'b0, sr_q[2:1]};
          enc_enable_nxt = 1'b1;
          tail_cnt_nxt   = tail_cnt_q + 2'd1;
        end else begin
          frame_done_nxt = 1'b1;
          gap_cnt_nxt    = GAP_LOAD;
          state_nxt      = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_nxt = GAP;
        gap_cnt_nxt = GAP_LOAD;
      end
    endcase
  end

  // State register; reset parks the block in GAP so upstream waits GAP_CYCLES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= GAP;
      gap_cnt_q  <= GAP_LOAD;
      tail_cnt_q <= 2'd0;
      bit_idx_q  <= 3'd0;
    end else begin
      state      <= state_nxt;
      gap_cnt_q  <= gap_cnt_nxt;
      tail_cnt_q <= tail_cnt_nxt;
      bit_idx_q  <= bit_idx_nxt;
    end
  end

  // Encoder state, latched byte and registered outputs; reset clears them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q     <= 8'd0;
      last_q     <= 1'b0;
      sr_q       <= 3'b000;
      enc_d      <= 2'b00;
      enc_enable <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      bit_count  <= 16'd0;
    end else begin
      byte_q     <= byte_nxt;
      last_q     <= last_nxt;
      sr_q       <= sr_nxt;
      enc_d      <= enc_d_nxt;
      enc_enable <= enc_enable_nxt;
      frame_done <= frame_done_nxt;
      underrun   <= underrun_nxt;
      bit_count  <= bit_count_nxt;
    end
  end

endmodule
